// File: rtl/text_pkg.sv
// Shared geometry, control-character codes and FSM state encoding for the
// UART-to-text-RAM cursor engine.
package text_pkg;

   localparam int TEXT_COLS = 32;
   localparam int TEXT_ROWS = 4;
   localparam int CELLS     = TEXT_COLS * TEXT_ROWS;

   localparam int ROW_W  = 2;
   localparam int COL_W  = 5;
   localparam int ADDR_W = ROW_W + COL_W;

   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_FF       = 8'h0C;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_BLANK    = 8'h20;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector. The history register has a parameterised reset value
// so a level already high when reset releases is not mistaken for an edge.
// The pulse is combinational from the registered history so the consumer
// acts on the same clock edge that sees the new level.
module edge_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev;

   // Track last sampled level of the strobe.
   always_ff @(posedge clk) begin
      if (reset) prev <= RESET_VAL;
      else       prev <= din;
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/uart_text_cursor.sv
// Cursor and control-character engine between the UART receiver and the
// 4x32 character RAM. Each received byte yields at most one RAM write; a
// full blank sweep runs after reset and on form-feed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | decode received bytes, move cursor, write printable/BS
// ST_CLEAR | write blank to addr 0..127, one per cycle; bytes dropped
module uart_text_cursor
   import text_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             wr_en,
   output logic [ROW_W-1:0] wr_row,
   output logic [COL_W-1:0] wr_col,
   output logic [7:0]       wr_data,
   output logic [ROW_W-1:0] cur_row,
   output logic [COL_W-1:0] cur_col,
   output logic             busy,
   output logic             drop
);

   state_t            state;
   logic [ADDR_W-1:0] sweep_addr;
   logic              rx_rise;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] cur_inc;
   logic [ADDR_W-1:0] bs_addr;
   logic              is_print;

   edge_detect #(.RESET_VAL(1'b1)) u_rx_edge (
      .clk   (clk),
      .reset (reset),
      .din   (rx_valid),
      .rise  (rx_rise)
   );

   // Row/col treated as one linear 7-bit address so wraps fall out of overflow.
   assign cur_addr = {cur_row, cur_col};
   assign cur_inc  = cur_addr + ADDR_W'(1);
   assign bs_addr  = (cur_addr == '0) ? '0 : cur_addr - ADDR_W'(1);
   assign is_print = (rx_data >= CH_PRINT_LO) && (rx_data <= CH_PRINT_HI);

   // Main FSM: sweep, byte decode, cursor update and registered RAM write.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
         busy       <= CLEAR_ON_RESET;
         wr_en      <= 1'b0;
         wr_row     <= '0;
         wr_col     <= '0;
         wr_data    <= 8'h00;
         drop       <= 1'b0;
         cur_row    <= '0;
         cur_col    <= '0;
         sweep_addr <= '0;
      end else begin
         wr_en <= 1'b0;
         drop  <= 1'b0;
         case (state)
            ST_CLEAR: begin
               wr_en              <= 1'b1;
               {wr_row, wr_col}   <= sweep_addr;
               wr_data            <= CH_BLANK;
               sweep_addr         <= sweep_addr + ADDR_W'(1);
               {cur_row, cur_col} <= '0;
               if (sweep_addr == ADDR_W'(CELLS - 1)) state <= ST_IDLE;
               if (rx_rise) drop <= 1'b1;
            end
            ST_IDLE: begin
               // busy stays high through the last sweep write, drops here.
               busy <= 1'b0;
               if (rx_rise) begin
                  if (is_print) begin
                     wr_en              <= 1'b1;
                     {wr_row, wr_col}   <= cur_addr;
                     wr_data            <= rx_data;
                     {cur_row, cur_col} <= cur_inc;
                  end else begin
                     case (rx_data)
                        CH_BS: begin
                           wr_en              <= 1'b1;
                           {wr_row, wr_col}   <= bs_addr;
                           wr_data            <= CH_BLANK;
                           {cur_row, cur_col} <= bs_addr;
                        end
                        CH_CR: cur_col <= '0;
                        CH_LF: begin
                           cur_row <= cur_row + ROW_W'(1);
                           cur_col <= '0;
                        end
                        CH_FF: begin
                           // First sweep write issues now so the sweep
                           // occupies exactly the next 128 cycles.
                           state              <= ST_CLEAR;
                           busy               <= 1'b1;
                           wr_en              <= 1'b1;
                           {wr_row, wr_col}   <= '0;
                           wr_data            <= CH_BLANK;
                           sweep_addr         <= ADDR_W'(1);
                           {cur_row, cur_col} <= '0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
